// File: rtl/lz77_stream_arbiter.sv
// lz77_stream_arbiter: hands one LZ77 encoder to NCH byte streams round-robin,
// one block (payload + zero pad) at a time, and tags encoder output with the owning channel.
module lz77_stream_arbiter #(
    parameter int NCH       = 4,
    parameter int BLOCK_LEN = 4096,
    parameter int PAD_LEN   = 16,
    parameter int TIMEOUT   = 65535,
    localparam int CW       = $clog2(NCH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NCH-1:0]   req_valid,
    input  logic [8*NCH-1:0] req_data,
    output logic [NCH-1:0]   req_ready,
    input  logic             enc_i_rdy,
    output logic             enc_i_en,
    output logic [7:0]       enc_i_data,
    input  logic             enc_o_en,
    input  logic [7:0]       enc_o_data,
    input  logic             enc_finish,
    output logic             out_valid,
    output logic [7:0]       out_data,
    output logic [CW-1:0]    out_ch,
    output logic             out_last,
    output logic             busy,
    output logic             err
);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, FEED, PAD, DRAIN, RELEASE} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] grant, last_grant, pick;
    logic [CW:0]   idx;
    logic [12:0]   byte_cnt;
    logic [TW-1:0] tcnt;
    logic          acc, fwd;

    always_comb begin
        state_nxt  = state;
        pick       = '0;
        idx        = '0;
        req_ready  = '0;
        enc_i_en   = 1'b0;
        enc_i_data = '0;
        acc        = 1'b0;
        fwd        = state inside {FEED, PAD, DRAIN};
        // walk downwards so the nearest channel after last_grant wins
        for (int i = NCH; i >= 1; i--) begin
            idx = (CW+1)'(last_grant) + (CW+1)'(i);
            if (idx >= (CW+1)'(NCH)) idx = idx - (CW+1)'(NCH);
            if (req_valid[idx[CW-1:0]]) pick = idx[CW-1:0];
        end
        case (state)
            IDLE: if (!enc_finish && |req_valid) state_nxt = FEED;
            FEED: begin
                req_ready[grant] = enc_i_rdy;
                enc_i_en         = req_valid[grant] & enc_i_rdy;
                enc_i_data       = req_data[{grant, 3'b000} +: 8];
                acc              = enc_i_en;
                if (enc_finish) state_nxt = RELEASE;
                else if (acc && byte_cnt == 13'(BLOCK_LEN - 1)) state_nxt = PAD;
            end
            PAD: begin
                enc_i_en = enc_i_rdy;
                acc      = enc_i_rdy;
                if (enc_finish) state_nxt = RELEASE;
                else if (acc && byte_cnt == 13'(PAD_LEN - 1)) state_nxt = DRAIN;
            end
            DRAIN: if (enc_finish || tcnt == TW'(TIMEOUT - 1)) state_nxt = RELEASE;
            RELEASE: if (!enc_finish) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            grant      <= '0;
            last_grant <= CW'(NCH - 1);
            byte_cnt   <= '0;
            tcnt       <= '0;
            err        <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_ch     <= '0;
            out_last   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && state_nxt == FEED) grant <= pick;
            byte_cnt <= (state_nxt != state) ? '0 : acc ? byte_cnt + 13'd1 : byte_cnt;
            tcnt     <= (state == DRAIN && state_nxt == DRAIN) ? tcnt + 1'b1 : '0;
            if (state == DRAIN && !enc_finish && tcnt == TW'(TIMEOUT - 1)) err <= 1'b1;
            if (state == RELEASE && !enc_finish) last_grant <= grant;
            // in RELEASE the encoder may keep o_en high; none of it belongs to the block
            out_valid <= fwd & enc_o_en;
            out_last  <= fwd & enc_o_en & enc_finish;
            if (fwd && enc_o_en) begin
                out_data <= enc_o_data;
                out_ch   <= grant;
            end
        end
    end

    assign busy = state != IDLE;
endmodule

// File: tb/tb_lz77_stream_arbiter.sv
// tb_lz77_stream_arbiter: random requesters and a toy encoder drive the arbiter;
// a block-level reference model predicts every handshake and tagged output byte.
module tb_lz77_stream_arbiter;
    localparam int NCH = 4, BL = 32, PL = 16, TO = 100, CW = 2;

    logic clk = 1'b0, rst_n = 1'b0;
    logic [NCH-1:0] req_valid = '0, req_ready;
    logic [8*NCH-1:0] req_data = '0;
    logic enc_i_rdy = 1'b0, enc_i_en, enc_o_en = 1'b0, enc_finish = 1'b0;
    logic [7:0] enc_i_data, enc_o_data = '0, out_data;
    logic out_valid, out_last, busy, err;
    logic [CW-1:0] out_ch;

    lz77_stream_arbiter #(.NCH(NCH), .BLOCK_LEN(BL), .PAD_LEN(PL), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .enc_i_rdy(enc_i_rdy), .enc_i_en(enc_i_en),
        .enc_i_data(enc_i_data), .enc_o_en(enc_o_en), .enc_o_data(enc_o_data),
        .enc_finish(enc_finish), .out_valid(out_valid), .out_data(out_data),
        .out_ch(out_ch), .out_last(out_last), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    int tests = 0, fails = 0;
    int pend[NCH], seq[NCH], hs[NCH];
    bit gap, rdy_rand, e_fin, e_force, e_echo_v;
    int fin_after, fin_hold, e_cnt, e_hold;
    logic [7:0] e_echo_d;
    bit m_busy, m_active, m_err, exp_ov, exp_ol;
    int m_owner, m_last, m_fed, m_drain, exp_och;
    int m_seq[NCH];
    logic [7:0] exp_od;
    int glog[$];
    logic [NCH-1:0] s_valid, s_ready;
    bit s_rdy, s_fin, s_oen, s_ien;
    logic [7:0] s_odata, s_idata;
    int cyc, n_acc, n_last, last_ch, fed_done_cyc, err_cyc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic drive();
        for (int k = 0; k < NCH; k++) begin
            req_valid[k] = pend[k] > 0 && (!busy || !gap || $urandom_range(0, 1) == 1);
            req_data[8*k +: 8] = 8'(k * 64 + seq[k]);
        end
        enc_finish = e_fin | e_force;
        enc_i_rdy  = !e_fin && (!rdy_rand || $urandom_range(0, 1) == 1);
        enc_o_en   = e_fin ? 1'b1 : e_echo_v;
        enc_o_data = e_fin ? 8'hE7 : e_echo_d ^ 8'hA5;
    endtask

    task automatic check_regs();
        chk("busy", busy, m_busy);
        chk("err", err, m_err);
        chk("out_valid", out_valid, exp_ov);
        chk("out_last", out_last, exp_ol);
        if (exp_ov) begin
            chk("out_data", out_data, exp_od);
            chk("out_ch", out_ch, exp_och);
        end
        if (out_last) begin
            n_last++;
            last_ch = out_ch;
        end
        if (err && err_cyc < 0) err_cyc = cyc;
    endtask

    task automatic check_comb();
        logic [NCH-1:0] er;
        bit ee;
        logic [7:0] ed;
        er = '0; ee = 0; ed = '0;
        if (m_active && m_fed < BL) begin
            er[m_owner] = enc_i_rdy;
            ee = req_valid[m_owner] && enc_i_rdy;
            ed = 8'(m_owner * 64 + m_seq[m_owner]);
        end else if (m_active && m_fed < BL + PL) begin
            ee = enc_i_rdy;
        end
        chk("req_ready", req_ready, er);
        chk("enc_i_en", enc_i_en, ee);
        if (ee) chk("enc_i_data", enc_i_data, ed);
    endtask

    task automatic update();
        bit drain, acc, found;
        int c;
        for (int k = 0; k < NCH; k++)
            if (s_valid[k] && s_ready[k]) begin
                seq[k]++; pend[k]--; hs[k]++;
            end
        acc = s_ien && s_rdy;
        e_echo_v = acc;
        e_echo_d = s_idata;
        if (acc) begin
            e_cnt++; n_acc++;
        end
        if (e_fin) begin
            e_hold--;
            if (e_hold == 0) begin
                e_fin = 0; e_cnt = 0;
            end
        end else if (fin_after != 0 && e_cnt == fin_after) begin
            e_fin = 1; e_hold = fin_hold;
        end
        // reference: one block = grant, BL payload accepts, PL zero accepts, then wait for finish
        if (!m_busy) begin
            exp_ov = 0; exp_ol = 0;
            if (!s_fin && |s_valid) begin
                found = 0;
                for (int i = 1; i <= NCH; i++) begin
                    c = (m_last + i) % NCH;
                    if (!found && s_valid[c]) begin
                        found = 1; m_owner = c;
                    end
                end
                m_busy = 1; m_active = 1; m_fed = 0; m_drain = 0;
                glog.push_back(m_owner);
            end
        end else if (m_active) begin
            exp_ov = s_oen;
            exp_ol = s_oen && s_fin;
            if (s_oen) begin
                exp_od = s_odata; exp_och = m_owner;
            end
            drain = m_fed == BL + PL;
            if (m_fed < BL) begin
                if (s_valid[m_owner] && s_rdy) begin
                    m_fed++; m_seq[m_owner]++;
                end
            end else if (!drain && s_rdy) m_fed++;
            if (!drain && m_fed == BL + PL) fed_done_cyc = cyc;
            if (s_fin) m_active = 0;
            else if (drain) begin
                m_drain++;
                if (m_drain == TO) begin
                    m_err = 1; m_active = 0;
                end
            end
        end else begin
            exp_ov = 0; exp_ol = 0;
            if (!s_fin) begin
                m_busy = 0; m_last = m_owner;
            end
        end
    endtask

    task automatic step();
        check_regs();
        drive();
        #1;
        check_comb();
        s_valid = req_valid; s_ready = req_ready; s_rdy = enc_i_rdy; s_fin = enc_finish;
        s_oen = enc_o_en; s_odata = enc_o_data; s_ien = enc_i_en; s_idata = enc_i_data;
        @(posedge clk);
        cyc++;
        update();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive();
        #1;
        chk("rst_req_ready", req_ready, 0);
        chk("rst_enc_i_en", enc_i_en, 0);
        chk("rst_enc_i_data", enc_i_data, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_ch", out_ch, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        m_busy = 0; m_active = 0; m_err = 0; m_last = NCH - 1;
        exp_ov = 0; exp_ol = 0; exp_od = '0; exp_och = 0;
        e_fin = 0; e_cnt = 0; e_hold = 0; e_echo_v = 0; e_echo_d = '0;
        glog.delete();
        for (int k = 0; k < NCH; k++) hs[k] = 0;
        n_acc = 0; n_last = 0; last_ch = -1;
    endtask

    task automatic run_blocks(input int n, input int bound);
        for (int i = 0; i < bound && !(glog.size() >= n && !m_busy); i++) step();
        chk("blocks_done", glog.size() >= n && !m_busy, 1);
    endtask

    initial begin
        int t2_exp[5] = '{0, 1, 2, 3, 0};
        gap = 0; rdy_rand = 0; e_force = 0; fin_after = 48; fin_hold = 3;
        cyc = 0; fed_done_cyc = -1; err_cyc = -1;
        for (int k = 0; k < NCH; k++) begin
            pend[k] = 0; seq[k] = 0; m_seq[k] = 0;
        end
        @(negedge clk);
        do_reset();

        // single channel, finish in DRAIN, o_en held two cycles into RELEASE
        pend[0] = 32;
        run_blocks(1, 400);
        repeat (3) step();
        chk("t1_handshakes", hs[0], 32);
        chk("t1_enc_accepts", n_acc, 48);
        chk("t1_last_count", n_last, 1);
        chk("t1_last_ch", last_ch, 0);
        chk("t1_grants", glog.size(), 1);

        // all channels continuously valid
        do_reset();
        fin_hold = 1;
        for (int k = 0; k < NCH; k++) pend[k] = 1000;
        run_blocks(5, 2000);
        for (int i = 0; i < 5; i++) chk("t2_grant_order", glog[i], t2_exp[i]);
        chk("t2_last_count", n_last, 5);
        for (int k = 0; k < NCH; k++) pend[k] = 0;
        repeat (3) step();

        // gapped requesters, 50% encoder ready
        do_reset();
        gap = 1; rdy_rand = 1; fin_hold = 2;
        for (int k = 0; k < NCH; k++) pend[k] = 64;
        for (int i = 0; i < 6000 && !(pend[0] + pend[1] + pend[2] + pend[3] == 0 && !m_busy); i++)
            step();
        repeat (3) step();
        for (int k = 0; k < NCH; k++) chk("t3_handshakes", hs[k], 64);
        chk("t3_enc_accepts", n_acc, 8 * 48);
        chk("t3_last_count", n_last, 8);
        gap = 0; rdy_rand = 0;

        // finish rises during FEED; unsent bytes stay with the requester
        do_reset();
        fin_after = 20; pend[1] = 40;
        for (int i = 0; i < 500 && glog.size() < 2; i++) step();
        chk("t4_handshakes", hs[1], 20);
        chk("t4_pending", pend[1], 20);
        chk("t4_last_count", n_last, 1);
        chk("t4_regrant", glog[1], 1);
        pend[1] = 0;

        // finish never comes: timeout sets sticky err
        do_reset();
        fin_after = 0; pend[3] = 32; fed_done_cyc = -1; err_cyc = -1;
        for (int i = 0; i < 400 && err_cyc < 0; i++) step();
        repeat (20) step();
        chk("t5_err_delay", err_cyc - fed_done_cyc, 100);
        chk("t5_err_sticky", err, 1);
        chk("t5_idle", busy, 0);
        fin_after = 48;

        // reset in the middle of feeding channel 0
        do_reset();
        pend[0] = 1000; pend[1] = 1000;
        for (int i = 0; i < 200 && !(glog.size() == 1 && m_fed == 10); i++) step();
        chk("t6_fed_before_reset", hs[0], 10);
        do_reset();
        for (int i = 0; i < 20 && glog.size() < 1; i++) step();
        chk("t6_grant_after_reset", glog[0], 0);
        run_blocks(2, 1000);
        pend[0] = 0; pend[1] = 0;
        repeat (3) step();

        // encoder still finishing while idle: no grant
        do_reset();
        e_force = 1; pend[2] = 32;
        repeat (10) step();
        chk("t7_no_grant", glog.size(), 0);
        chk("t7_busy", busy, 0);
        e_force = 0;
        run_blocks(1, 400);
        chk("t7_grant", glog[0], 2);
        repeat (3) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/lz77_stream_arbiter.md
# lz77_stream_arbiter

Shares one LZ77 encoder between NCH independent byte-stream requesters, one whole block at a time. It sits between the requester ports and the encoder's input stream and output byte port. The arbiter grants a channel round-robin and feeds exactly BLOCK_LEN bytes from that channel, then PAD_LEN zero bytes to flush the look-ahead window. It forwards encoder output tagged with the channel ID and frees the encoder once the encoder's finish flag has fallen.

## Interface
- NCH, 4: number of requesters (2..8); CW = clog2(NCH)
- BLOCK_LEN, 4096: payload bytes per block; matches the encoder finish threshold
- PAD_LEN, 16: zero bytes fed after the payload (look-ahead depth)
- TIMEOUT, 65535: max cycles in DRAIN without enc_finish before err is raised
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NCH  per-channel byte valid
- req_data  in  8*NCH  per-channel byte; channel k at [8k+7:8k]
- req_ready  out  NCH  per-channel accept
- enc_i_rdy  in  1  encoder input ready
- enc_i_en  out  1  encoder input strobe
- enc_i_data  out  8  encoder input byte
- enc_o_en  in  1  encoder output strobe
- enc_o_data  in  8  encoder output byte
- enc_finish  in  1  encoder block-done level
- out_valid  out  1  tagged output strobe
- out_data  out  8  output byte
- out_ch  out  CW  channel owning out_data
- out_last  out  1  final byte of the block
- busy  out  1  state != IDLE
- err  out  1  sticky DRAIN timeout; cleared only by reset

## Operation
- States: IDLE, FEED, PAD, DRAIN, RELEASE.
- IDLE:
  - Scan req_valid starting at last_grant+1 (mod NCH) and pick the first set bit.
  - Latch it into grant, clear byte_cnt, go to FEED.
  - Ignore req_valid while enc_finish=1.
- FEED (combinational path):
  - req_ready[grant] = enc_i_rdy; all other req_ready bits are 0.
  - enc_i_en = req_valid[grant] & enc_i_rdy; enc_i_data = granted byte.
  - Each accepted byte increments byte_cnt (13 bits).
  - The accept at byte_cnt==BLOCK_LEN-1 goes to PAD with byte_cnt cleared.
- PAD:
  - enc_i_en = enc_i_rdy, enc_i_data = 8'h00.
  - After PAD_LEN accepts, go to DRAIN.
- DRAIN: no input is driven. Go to RELEASE on the first cycle enc_finish=1.
- Output forwarding:
  - Active in FEED, PAD and DRAIN (the encoder emits while it is still consuming input).
  - out_valid = enc_o_en, out_data = enc_o_data, out_ch = grant, all registered with 1-cycle latency.
  - out_last is registered high with the byte whose cycle has enc_finish=1 and enc_o_en=1.
  - If enc_finish rises in FEED or PAD, forward that byte with out_last, then go to RELEASE. The remaining input is not fed, and the requester keeps any unsent bytes.
- RELEASE:
  - enc_o_en is ignored; the encoder may hold o_en high here.
  - Wait for enc_finish=0, then set last_grant=grant and go to IDLE.
- The timeout counter runs only in DRAIN. At TIMEOUT it sets err and forces RELEASE.

## Timing
- Reset values:
  - All outputs are 0, with req_ready = 0 and out_ch = 0.
  - State is IDLE; last_grant = NCH-1, so channel 0 wins first.
- Grant latency: IDLE to FEED in 1 cycle; the first byte can be accepted in the first FEED cycle.
- Throughput: 1 byte/cycle while enc_i_rdy=1 and req_valid[grant]=1. A stall on either side holds byte_cnt.
- Output latency: 1 cycle from enc_o_en to out_valid. At most 1 out_last per grant.
- Simultaneous requests: exactly one grant. A channel that loses waits at most NCH-1 blocks.
- A requester dropping req_valid mid-block keeps the grant; there is no preemption.
- enc_finish already high in IDLE: wait, no grant.
- Reset mid-block: everything returns to reset values asynchronously. The partially fed block is lost, and the encoder is reset by the same rst_n.

## Test plan
- Single channel 0, BLOCK_LEN=32, PAD_LEN=16, encoder model asserts finish after the 48th input: exactly 32 req_ready handshakes, then 16 zero bytes; out_last with out_ch=0; back in IDLE 1 cycle after finish falls.
- All 4 channels valid continuously: grants in order 0,1,2,3,0; every out byte's out_ch equals the current grant; no interleaving of channels.
- enc_i_rdy toggled 50% and req_valid gapped: byte_cnt still counts exactly 32, and no byte is duplicated or dropped (scoreboard compare).
- Model keeps enc_o_en=1 for 2 cycles after finish: out_valid forwards only the finish-cycle byte with out_last=1, and nothing in RELEASE.
- Finish never asserted, TIMEOUT=100: err=1 after 100 DRAIN cycles, then RELEASE; err stays 1 until rst_n pulse.
- rst_n low for 1 cycle in mid-FEED at byte 10: all outputs 0 in that cycle; after reset the next grant goes to channel 0.
